// File: rtl/mcmult_issuer_if.sv
// Operand, multiplier and result signals of the multicycle-multiplier issuer.
// master = the issuer itself; slave = its environment (producer, multiplier, consumer).
interface mcmult_issuer_if #(
    parameter int N = 8,
    parameter int M = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             in_sign;
    logic [N-1:0]     in_a;
    logic [M-1:0]     in_b;
    logic             mul_start;
    logic             mul_sign;
    logic [N-1:0]     mul_aa;
    logic [M-1:0]     mul_bb;
    logic [N+M-1:0]   mul_out;
    logic             res_valid;
    logic             res_ready;
    logic [N+M-1:0]   res_data;
    logic             res_sign;
    logic             busy;

    modport master (
        input  in_valid, in_sign, in_a, in_b, mul_out, res_ready,
        output in_ready, mul_start, mul_sign, mul_aa, mul_bb,
               res_valid, res_data, res_sign, busy
    );

    modport slave (
        output in_valid, in_sign, in_a, in_b, mul_out, res_ready,
        input  in_ready, mul_start, mul_sign, mul_aa, mul_bb,
               res_valid, res_data, res_sign, busy
    );
endinterface

// File: rtl/mcmult_issuer.sv
// Issues operand pairs to a multicycle multiplier at most once every II cycles,
// tracks products through a LAT-deep valid pipe and queues them in a credited FIFO.
module mcmult_issuer #(
    parameter int N     = 8,
    parameter int M     = 8,
    parameter int II    = 4,
    parameter int LAT   = 4,
    parameter int DEPTH = 4
) (
    input logic            clk,
    input logic            rst,
    mcmult_issuer_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(II);
    localparam int W  = N + M;

    logic [IW-1:0]  ivl_cnt;
    logic [LAT:0]   vld_pipe;   // [0] is mul_start; [i] is the start issued i cycles ago
    logic [LAT:0]   sgn_pipe;
    logic           sign_q;
    logic [N-1:0]   aa_q;
    logic [M-1:0]   bb_q;
    logic [CW-1:0]  credit;
    logic [AW:0]    wptr, rptr;
    logic [W:0]     mem [DEPTH];

    logic in_rdy, hs, empty, rvalid, pop, cap;

    // A handshake in the previous cycle is exactly vld_pipe[0], so one term covers both.
    assign in_rdy = (ivl_cnt == '0) && !vld_pipe[0] && (credit < CW'(DEPTH)) && !rst;
    assign hs     = bus.in_valid && in_rdy;
    assign empty  = (wptr == rptr);
    assign rvalid = !empty && !rst;
    assign pop    = rvalid && bus.res_ready;
    assign cap    = vld_pipe[LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            ivl_cnt  <= '0;
            vld_pipe <= '0;
            sgn_pipe <= '0;
            sign_q   <= 1'b0;
            aa_q     <= '0;
            bb_q     <= '0;
            credit   <= '0;
            wptr     <= '0;
            rptr     <= '0;
        end else begin
            vld_pipe <= {vld_pipe[LAT-1:0], hs};
            sgn_pipe <= {sgn_pipe[LAT-1:0], bus.in_sign};
            if (hs) begin
                aa_q    <= bus.in_a;
                bb_q    <= bus.in_b;
                sign_q  <= bus.in_sign;
                ivl_cnt <= IW'(II - 1);
            end else if (ivl_cnt != '0) begin
                ivl_cnt <= ivl_cnt - IW'(1);
            end
            case ({hs, pop})
                2'b10:   credit <= credit + CW'(1);
                2'b01:   credit <= credit - CW'(1);
                default: credit <= credit;
            endcase
            if (cap) wptr <= wptr + (AW+1)'(1);
            if (pop) rptr <= rptr + (AW+1)'(1);
        end
    end

    // Credits bound in-flight + queued to DEPTH, so a capture always finds a free slot.
    always_ff @(posedge clk) begin
        if (!rst && cap) mem[wptr[AW-1:0]] <= {sgn_pipe[LAT], bus.mul_out};
    end

    assign bus.in_ready  = in_rdy;
    assign bus.mul_start = vld_pipe[0] && !rst;
    assign bus.mul_sign  = sign_q && !rst;
    assign bus.mul_aa    = rst ? '0 : aa_q;
    assign bus.mul_bb    = rst ? '0 : bb_q;
    assign bus.res_valid = rvalid;
    assign {bus.res_sign, bus.res_data} = rvalid ? mem[rptr[AW-1:0]] : '0;
    assign bus.busy      = !rst && ((credit != '0) || vld_pipe[0]);
endmodule

// File: tb/tb_mcmult_issuer.sv
// Directed bench for mcmult_issuer with a LAT-deep behavioural multiplier.
module tb_mcmult_issuer;
    localparam int N = 8, M = 8, II = 4, LAT = 4, DEPTH = 4;

    logic clk, rst;
    mcmult_issuer_if #(.N(N), .M(M)) bus ();

    mcmult_issuer #(.N(N), .M(M), .II(II), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .bus(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] prod(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic signed [15:0] sa, sb;
        sa = s ? {{8{a[7]}}, a} : {8'h00, a};
        sb = s ? {{8{b[7]}}, b} : {8'h00, b};
        return 16'(sa * sb);
    endfunction

    // Multiplier model: product of the held operands appears LAT cycles after mul_start.
    logic [15:0] mp [1:LAT];
    always @(posedge clk) begin
        mp[1] <= prod(bus.mul_aa, bus.mul_bb, bus.mul_sign);
        for (int i = 2; i <= LAT; i++) mp[i] <= mp[i-1];
    end
    assign bus.mul_out = mp[LAT];

    int vectors = 0, miscompares = 0;
    logic [16:0] expq [$];
    int sent, got, last_start, n, hs_cnt, st_cnt, seen;
    logic [7:0] a_v, b_v;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; bus.in_valid = 0; bus.in_sign = 0; bus.in_a = 0; bus.in_b = 0; bus.res_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_mul_start", bus.mul_start, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_mul_aa", bus.mul_aa, 0);
        chk("rst_res_data", {bus.res_sign, bus.res_data}, 0);
        rst = 1'b0;
        #1 chk("post_rst_ready", bus.in_ready, 1);

        // Unsigned 0xFF * 0xFF
        bus.in_valid = 1; bus.in_a = 8'hFF; bus.in_b = 8'hFF; bus.in_sign = 0;
        @(negedge clk);
        bus.in_valid = 0;
        chk("u_mul_start", bus.mul_start, 1);
        chk("u_mul_ops", {bus.mul_sign, bus.mul_aa, bus.mul_bb}, {1'b0, 16'hFFFF});
        chk("u_in_ready_low", bus.in_ready, 0);
        chk("u_busy", bus.busy, 1);
        @(negedge clk);
        chk("u_start_one_cycle", bus.mul_start, 0);
        repeat (LAT - 1) @(negedge clk);
        chk("u_valid_not_early", bus.res_valid, 0);
        @(negedge clk);
        chk("u_valid_rise", bus.res_valid, 1);
        chk("u_res", {bus.res_sign, bus.res_data}, {1'b0, 16'hFE01});
        @(negedge clk);
        chk("u_res_hold", {bus.res_valid, bus.res_sign, bus.res_data}, {2'b10, 16'hFE01});
        chk("u_ops_held", bus.mul_aa, 8'hFF);
        bus.res_ready = 1;
        @(negedge clk);
        bus.res_ready = 0;
        chk("u_popped", bus.res_valid, 0);
        chk("u_idle", bus.busy, 0);

        // Signed 0xFF * 0x02
        n = 0;
        while (!bus.in_ready && n < 20) begin @(negedge clk); n++; end
        chk("s_ready", bus.in_ready, 1);
        bus.in_valid = 1; bus.in_a = 8'hFF; bus.in_b = 8'h02; bus.in_sign = 1;
        @(negedge clk);
        bus.in_valid = 0; bus.res_ready = 1;
        n = 0;
        while (!bus.res_valid && n < 20) begin @(negedge clk); n++; end
        chk("s_valid", bus.res_valid, 1);
        chk("s_res", {bus.res_sign, bus.res_data}, {1'b1, 16'hFFFE});
        chk("s_mul_sign", bus.mul_sign, 1);
        @(negedge clk);
        chk("s_popped", bus.res_valid, 0);

        // Streaming: 10 pairs, consumer always ready
        sent = 0; got = 0; last_start = -1; n = 0;
        while ((sent < 10 || got < 10) && n < 200) begin
            if (bus.mul_start) begin
                if (last_start >= 0) chk("stream_spacing", n - last_start, II);
                last_start = n;
            end
            if (bus.res_valid) begin
                if (expq.size() == 0) chk("stream_extra", 1, 0);
                else chk("stream_data", {bus.res_sign, bus.res_data}, expq.pop_front());
                got++;
            end
            a_v = 8'(sent * 37 + 5); b_v = 8'(250 - sent * 11);
            bus.in_valid = (sent < 10); bus.in_a = a_v; bus.in_b = b_v; bus.in_sign = sent[0];
            if (bus.in_valid && bus.in_ready) begin
                expq.push_back({sent[0], prod(a_v, b_v, sent[0])});
                sent++;
            end
            @(negedge clk); n++;
        end
        bus.in_valid = 0;
        chk("stream_count", got, 10);

        // Backpressure: consumer stalled, credits run out after DEPTH issues
        bus.res_ready = 0; hs_cnt = 0; st_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.mul_start) st_cnt++;
            a_v = 8'(hs_cnt * 53 + 9); b_v = 8'(hs_cnt * 29 + 100);
            bus.in_valid = 1; bus.in_a = a_v; bus.in_b = b_v; bus.in_sign = hs_cnt[1];
            if (bus.in_ready) begin
                expq.push_back({hs_cnt[1], prod(a_v, b_v, hs_cnt[1])});
                hs_cnt++;
            end
            @(negedge clk);
        end
        chk("bp_handshakes", hs_cnt, DEPTH);
        chk("bp_starts", st_cnt, DEPTH);
        chk("bp_in_ready", bus.in_ready, 0);
        chk("bp_head", {bus.res_valid, bus.res_sign, bus.res_data}, {1'b1, expq[0]});
        bus.res_ready = 1;
        @(negedge clk);
        bus.res_ready = 0;
        void'(expq.pop_front());
        chk("bp_head_after_pop", {bus.res_sign, bus.res_data}, expq[0]);
        n = 0; seen = 0;
        while (!seen && n < 10) begin
            a_v = 8'hC3; b_v = 8'h5A;
            bus.in_valid = 1; bus.in_a = a_v; bus.in_b = b_v; bus.in_sign = 1;
            if (bus.in_ready) begin seen = 1; expq.push_back({1'b1, prod(a_v, b_v, 1'b1)}); end
            @(negedge clk); n++;
        end
        bus.in_valid = 0;
        chk("bp_one_new_hs", seen, 1);
        chk("bp_new_start", bus.mul_start, 1);
        // Pop in the very cycle the new product is captured
        repeat (LAT) @(negedge clk);
        chk("cap_pop_head", {bus.res_valid, bus.res_sign, bus.res_data}, {1'b1, expq[0]});
        bus.res_ready = 1;
        @(negedge clk);
        bus.res_ready = 0;
        void'(expq.pop_front());
        chk("cap_pop_next", {bus.res_sign, bus.res_data}, expq[0]);
        got = 0; n = 0; bus.res_ready = 1;
        while (bus.res_valid && n < 20) begin
            if (expq.size() == 0) chk("drain_extra", 1, 0);
            else chk("drain_data", {bus.res_sign, bus.res_data}, expq.pop_front());
            got++;
            @(negedge clk); n++;
        end
        bus.res_ready = 0;
        chk("drain_count", got, 3);
        chk("drain_idle", bus.busy, 0);

        // Reset two cycles after mul_start discards the pending product
        n = 0;
        while (!bus.in_ready && n < 20) begin @(negedge clk); n++; end
        bus.in_valid = 1; bus.in_a = 8'h12; bus.in_b = 8'h34; bus.in_sign = 0;
        @(negedge clk);
        bus.in_valid = 0;
        chk("mr_start", bus.mul_start, 1);
        repeat (2) @(negedge clk);
        rst = 1;
        #1;
        chk("mr_rst_busy", bus.busy, 0);
        chk("mr_rst_ready", bus.in_ready, 0);
        chk("mr_rst_aa", bus.mul_aa, 0);
        @(negedge clk);
        rst = 0; bus.res_ready = 0; seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.res_valid) seen = 1;
            @(negedge clk);
        end
        chk("mr_no_capture", seen, 0);
        chk("mr_busy", bus.busy, 0);
        chk("mr_ready", bus.in_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
